// File: rtl/mmio_bus_mux.sv
// mmio_bus_mux
//   Routes single-outstanding CPU MMIO requests to one of NUM_TARGETS
//   slots. The slot is chosen by the top address byte. The block also
//   reports bus errors for unmapped accesses and for target timeouts.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   cpu_valid       request strobe, sampled only while idle
//   cpu_addr        byte address; [31:24] selects the slot, [9:2] is the word
//   cpu_wstrb       byte write strobes (all zero = read)
//   cpu_wdata       write data
//   force_trap      answer the request with ERR_DATA, no target access
//   cpu_ready       one-cycle completion pulse
//   cpu_rdata       registered read data, valid with cpu_ready
//   tgt_cs          one-hot select, high only while a target is accessed
//   tgt_we          write enable, equals |cpu_wstrb
//   tgt_address     word address, equals cpu_addr[9:2]
//   tgt_wdata       write data, equals cpu_wdata
//   tgt_rdata       flattened per-slot read data (slot i at [32i+31:32i])
//   tgt_ready       per-slot ready flags
//   err_clear       clears err_count
//   bus_error       one-cycle error pulse, coincident with cpu_ready
//   err_addr        address of the most recent error
//   err_count       saturating error counter
module mmio_bus_mux #(
   parameter int          NUM_TARGETS     = 8,
   parameter logic [127:0] TARGET_PREFIXES = 128'h0,
   parameter int          TIMEOUT_CYCLES  = 255,
   parameter logic [31:0] ERR_DATA        = 32'h0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_valid,
   input  logic [31:0]               cpu_addr,
   input  logic [3:0]                cpu_wstrb,
   input  logic [31:0]               cpu_wdata,
   input  logic                      force_trap,
   output logic                      cpu_ready,
   output logic [31:0]               cpu_rdata,
   output logic [NUM_TARGETS-1:0]    tgt_cs,
   output logic                      tgt_we,
   output logic [7:0]                tgt_address,
   output logic [31:0]               tgt_wdata,
   input  logic [NUM_TARGETS*32-1:0] tgt_rdata,
   input  logic [NUM_TARGETS-1:0]    tgt_ready,
   input  logic                      err_clear,
   output logic                      bus_error,
   output logic [31:0]               err_addr,
   output logic [7:0]                err_count
);

   localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   // Value of the ACCESS cycle counter in the last cycle before a timeout.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]             state_reg, state_next;
   logic [SEL_W-1:0]       sel_reg, sel_next;
   logic [15:0]            tmo_cnt_reg, tmo_cnt_next;
   logic [31:0]            req_addr_reg, req_addr_next;
   logic [31:0]            rdata_next;
   logic                   ready_next;
   logic                   err_event;

   logic [NUM_TARGETS-1:0] prefix_hit;
   logic [NUM_TARGETS-1:0] slot_is_sel;
   logic                   any_hit;
   logic [SEL_W-1:0]       hit_idx;
   logic                   sel_ready;
   logic [31:0]            sel_rdata;
   logic                   timeout_hit;

   // Target-side write/address signals are plain pass-throughs.
   assign tgt_we      = |cpu_wstrb;
   assign tgt_address = cpu_addr[9:2];
   assign tgt_wdata   = cpu_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_slot
         assign prefix_hit[gi]  = (cpu_addr[31:24] == TARGET_PREFIXES[8*gi +: 8]);
         assign slot_is_sel[gi] = (sel_reg == SEL_W'(gi));
         // Chip select is decoded from the state so that an asynchronous
         // reset drops it immediately.
         assign tgt_cs[gi]      = (state_reg == ACCESS) && slot_is_sel[gi];
      end
   endgenerate

   // Priority encoder: scan downward so the lowest matching slot is last
   // to write and therefore wins.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if (prefix_hit[i]) begin
            any_hit = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // Only the selected slot's ready and read data are visible to the FSM.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (slot_is_sel[i]) begin
            sel_ready = tgt_ready[i];
            sel_rdata = tgt_rdata[32*i +: 32];
         end
      end
   end

   assign timeout_hit = TIMEOUT_EN && (tmo_cnt_reg == TIMEOUT_LAST);

   always_comb begin
      state_next    = state_reg;
      sel_next      = sel_reg;
      tmo_cnt_next  = tmo_cnt_reg;
      req_addr_next = req_addr_reg;
      rdata_next    = cpu_rdata;
      ready_next    = 1'b0;
      err_event     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cpu_valid) begin
               req_addr_next = cpu_addr;
               if (force_trap) begin
                  state_next = RESP;
                  ready_next = 1'b1;
                  rdata_next = ERR_DATA;
               end else if (any_hit) begin
                  state_next   = ACCESS;
                  sel_next     = hit_idx;
                  tmo_cnt_next = '0;
               end else begin
                  state_next = RESP;
                  ready_next = 1'b1;
                  rdata_next = ERR_DATA;
                  err_event  = 1'b1;
               end
            end
         end
         ACCESS: begin
            // cpu_valid is deliberately not looked at: an accepted access
            // always runs to completion.
            if (sel_ready) begin
               state_next   = RESP;
               ready_next   = 1'b1;
               rdata_next   = sel_rdata;
               tmo_cnt_next = '0;
            end else if (timeout_hit) begin
               state_next   = RESP;
               ready_next   = 1'b1;
               rdata_next   = ERR_DATA;
               err_event    = 1'b1;
               tmo_cnt_next = '0;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 16'd1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         sel_reg      <= '0;
         tmo_cnt_reg  <= '0;
         req_addr_reg <= '0;
         cpu_ready    <= 1'b0;
         cpu_rdata    <= '0;
      end else begin
         state_reg    <= state_next;
         sel_reg      <= sel_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         req_addr_reg <= req_addr_next;
         cpu_ready    <= ready_next;
         cpu_rdata    <= rdata_next;
      end
   end

   // Error reporting. An unmapped error is raised while still idle, so the
   // live address is used; a timeout uses the address captured at accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_error <= 1'b0;
         err_addr  <= '0;
         err_count <= '0;
      end else begin
         bus_error <= err_event;
         if (err_event) begin
            err_addr <= (state_reg == IDLE) ? cpu_addr : req_addr_reg;
            if (err_clear) begin
               err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end else if (err_clear) begin
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mmio_bus_mux.sv
module tb_mmio_bus_mux;

   localparam int          NT  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cpu_valid = 1'b0;
   logic [31:0]       cpu_addr = '0;
   logic [3:0]        cpu_wstrb = '0;
   logic [31:0]       cpu_wdata = '0;
   logic              force_trap = 1'b0;
   logic              cpu_ready;
   logic [31:0]       cpu_rdata;
   logic [NT-1:0]     tgt_cs;
   logic              tgt_we;
   logic [7:0]        tgt_address;
   logic [31:0]       tgt_wdata;
   logic [NT*32-1:0]  tgt_rdata;
   logic [NT-1:0]     tgt_ready = '0;
   logic              err_clear = 1'b0;
   logic              bus_error;
   logic [31:0]       err_addr;
   logic [7:0]        err_count;

   // Slots: 0 -> 0x10, 1 -> 0x20, 2 -> 0xC2, 3 -> 0x20 (shadowed by slot 1).
   mmio_bus_mux #(
      .NUM_TARGETS    (NT),
      .TARGET_PREFIXES(128'h20C2_2010),
      .TIMEOUT_CYCLES (4),
      .ERR_DATA       (ERR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_valid  (cpu_valid),
      .cpu_addr   (cpu_addr),
      .cpu_wstrb  (cpu_wstrb),
      .cpu_wdata  (cpu_wdata),
      .force_trap (force_trap),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .tgt_cs     (tgt_cs),
      .tgt_we     (tgt_we),
      .tgt_address(tgt_address),
      .tgt_wdata  (tgt_wdata),
      .tgt_rdata  (tgt_rdata),
      .tgt_ready  (tgt_ready),
      .err_clear  (err_clear),
      .bus_error  (bus_error),
      .err_addr   (err_addr),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   assign tgt_rdata = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};

   function automatic logic [31:0] slot_data(input int s);
      case (s)
         0:       return 32'hA0A0_0000;
         1:       return 32'hB1B1_0001;
         2:       return 32'hC2C2_0002;
         default: return 32'hD3D3_0003;
      endcase
   endfunction

   function automatic logic [NT-1:0] onehot(input int s);
      logic [NT-1:0] v;
      v = '0;
      if (s >= 0) v[s] = 1'b1;
      return v;
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        trap;
      int          slot;    // expected selected slot, -1 = none
      int          delay;   // ACCESS cycles before target ready (large = never)
      int          lat;     // expected cycles from request to cpu_ready
      logic        err;     // expected bus error
   } vec_t;

   vec_t vecs[9];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_cnt   = 0;
   logic [31:0] m_addr  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request from an idle negedge and follow it to completion.
   task automatic do_txn(input vec_t v, input bit clr);
      int          lat;
      int          acc;
      bit          done;
      logic [31:0] exp_rdata;
      cpu_valid  = 1'b1;
      cpu_addr   = v.addr;
      cpu_wstrb  = v.wstrb;
      cpu_wdata  = v.wdata;
      force_trap = v.trap;
      err_clear  = clr;
      #1;
      chk("tgt_address", {24'h0, tgt_address}, {24'h0, v.addr[9:2]});
      chk("tgt_we", {31'h0, tgt_we}, {31'h0, (v.wstrb != 4'h0)});
      chk("tgt_wdata", tgt_wdata, v.wdata);
      chk("idle_cs", {28'h0, tgt_cs}, 32'h0);
      lat  = 0;
      acc  = 0;
      done = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         cpu_valid  = 1'b0;
         force_trap = 1'b0;
         err_clear  = 1'b0;
         if (cpu_ready) begin
            done = 1;
         end else begin
            chk("access_cs", {28'h0, tgt_cs}, {28'h0, onehot(v.slot)});
            // Unselected slots look ready until the selected one answers.
            tgt_ready = (acc == v.delay) ? {NT{1'b1}} : ~onehot(v.slot);
            acc++;
         end
      end
      tgt_ready = '0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_wait: got no cpu_ready after %0d cycles expected %0d", lat, v.lat);
      end else begin
         if (v.err) begin
            m_addr = v.addr;
            m_cnt  = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
         end else if (clr) begin
            m_cnt = 0;
         end
         exp_rdata = (v.slot < 0 || v.err) ? ERR : slot_data(v.slot);
         chk("latency", lat, v.lat);
         chk("cpu_rdata", cpu_rdata, exp_rdata);
         chk("bus_error", {31'h0, bus_error}, {31'h0, v.err});
         chk("resp_cs", {28'h0, tgt_cs}, 32'h0);
         chk("err_count", {24'h0, err_count}, m_cnt);
         chk("err_addr", err_addr, m_addr);
         @(negedge clk);
         chk("ready_pulse", {31'h0, cpu_ready}, 32'h0);
         chk("error_pulse", {31'h0, bus_error}, 32'h0);
      end
   endtask

   initial begin
      vec_t sat_v;
      vecs[0] = '{32'hC200_0010, 4'h0, 32'h0,         1'b0,  2,  0, 2, 1'b0};
      vecs[1] = '{32'h1000_0ABC, 4'hF, 32'h1234_5678, 1'b0,  0,  1, 3, 1'b0};
      vecs[2] = '{32'h2000_0040, 4'h0, 32'h0,         1'b0,  1,  2, 4, 1'b0};
      vecs[3] = '{32'hC500_0000, 4'h0, 32'h0,         1'b0, -1,  0, 1, 1'b1};
      vecs[4] = '{32'hC200_0100, 4'h0, 32'h0,         1'b0,  2, 99, 5, 1'b1};
      vecs[5] = '{32'h1000_0004, 4'h0, 32'h0,         1'b0,  0,  3, 5, 1'b0};
      vecs[6] = '{32'hC200_0010, 4'h0, 32'h0,         1'b1, -1,  0, 1, 1'b0};
      vecs[7] = '{32'h2000_0008, 4'h1, 32'h0000_00AA, 1'b0,  1,  0, 2, 1'b0};
      vecs[8] = '{32'h5500_0000, 4'h0, 32'h0,         1'b1, -1,  0, 1, 1'b0};
      sat_v   = '{32'hE000_0000, 4'h0, 32'h0,         1'b0, -1,  0, 1, 1'b1};

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_cs", {28'h0, tgt_cs}, 32'h0);
      chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);
      chk("rst_err_count", {24'h0, err_count}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_txn(vecs[i], 1'b0);
         $display("[TB] vector %0d addr=%h lat=%0d err=%0d count=%0d", i, vecs[i].addr, vecs[i].lat, vecs[i].err, m_cnt);
      end

      // Error counter saturation.
      for (int i = 0; i < 300; i++) do_txn(sat_v, 1'b0);
      chk("sat_count", {24'h0, err_count}, 32'd255);
      $display("[TB] 300 unmapped accesses, err_count=%0d", err_count);

      // Clear coinciding with an error leaves exactly one counted.
      sat_v.addr = 32'hE100_0004;
      do_txn(sat_v, 1'b1);
      chk("clear_with_err", {24'h0, err_count}, 32'd1);
      $display("[TB] clear with error, err_count=%0d", err_count);

      // Clear on its own.
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      m_cnt = 0;
      chk("clear_alone", {24'h0, err_count}, 32'd0);
      $display("[TB] clear alone, err_count=%0d", err_count);

      // Reset in the middle of an ACCESS.
      cpu_valid = 1'b1;
      cpu_addr  = 32'hC200_0020;
      cpu_wstrb = 4'h0;
      @(negedge clk);
      cpu_valid = 1'b0;
      chk("pre_reset_cs", {28'h0, tgt_cs}, 32'h4);
      @(negedge clk);
      chk("pre_reset_cs2", {28'h0, tgt_cs}, 32'h4);
      reset = 1'b1;
      #1;
      chk("mid_reset_cs", {28'h0, tgt_cs}, 32'h0);
      chk("mid_reset_ready", {31'h0, cpu_ready}, 32'h0);
      chk("mid_reset_rdata", cpu_rdata, 32'h0);
      chk("mid_reset_err_addr", err_addr, 32'h0);
      $display("[TB] reset during access, tgt_cs=%b cpu_ready=%b", tgt_cs, cpu_ready);
      @(negedge clk);
      reset  = 1'b0;
      m_cnt  = 0;
      m_addr = '0;
      @(negedge clk);
      do_txn(vecs[0], 1'b0);
      $display("[TB] post-reset access rdata=%h", cpu_rdata);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
